// File: rtl/targ_uart_rx_ctrl.sv
// Controller and receive buffer behind the target-side UART receiver.
// It gates reception until the line is idle, buffers good bytes, counts framing errors and tracks packets.
module targ_uart_rx_ctrl #(
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned BAUD_W = 16,
  parameter logic [BAUD_W-1:0] DEFAULT_BAUD_INC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_enable,
  input  logic                 cfg_flush,
  input  logic [BAUD_W-1:0]    cfg_baud_inc,
  output logic [BAUD_W-1:0]    rx_baud_inc,
  input  logic                 rx_data_ready,
  input  logic                 rx_data_error,
  input  logic [7:0]           rx_data,
  input  logic                 rx_endofpacket,
  input  logic                 rx_idle,
  input  logic                 rd_en,
  output logic [7:0]           rd_data,
  output logic                 rd_valid,
  output logic [FIFO_AW:0]     fifo_count,
  output logic                 fifo_empty,
  output logic                 overflow,
  output logic [7:0]           err_count,
  output logic                 pkt_done,
  output logic [7:0]           pkt_len,
  output logic [1:0]           state_o
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW = FIFO_AW + 1;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    WAIT_IDLE = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  state_t state, stateNext;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wrPtr, rdPtr;
  logic [7:0]         byteCnt;
  logic [CW-1:0]      countNext;
  logic               isActive, hasSpace, rdAcc, wrAcc, dropByte;

  // Next-state logic and FIFO handshake decode
  always_comb begin
    stateNext = OFF;
    isActive  = 1'b0;
    hasSpace  = 1'b0;
    rdAcc     = 1'b0;
    wrAcc     = 1'b0;
    dropByte  = 1'b0;
    countNext = fifo_count;

    case (state)
      OFF:       stateNext = cfg_enable ? WAIT_IDLE : OFF;
      WAIT_IDLE: begin
        if (!cfg_enable)  stateNext = OFF;
        else if (rx_idle) stateNext = ACTIVE;
        else              stateNext = WAIT_IDLE;
      end
      ACTIVE:    stateNext = cfg_enable ? ACTIVE : OFF;
      default:   stateNext = OFF;
    endcase

    isActive = (state == ACTIVE);
    rdAcc    = rd_en && (fifo_count != '0) && !cfg_flush;
    hasSpace = (fifo_count < CW'(DEPTH)) || rdAcc;
    wrAcc    = isActive && rx_data_ready && hasSpace && !cfg_flush;
    dropByte = isActive && rx_data_ready && !hasSpace;

    if (cfg_flush)          countNext = '0;
    else if (wrAcc && !rdAcc) countNext = fifo_count + CW'(1);
    else if (rdAcc && !wrAcc) countNext = fifo_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= OFF;
    else       state <= stateNext;
  end

  // Storage array carries no reset; occupancy and pointers define validity
  always_ff @(posedge clk) begin
    if (wrAcc) mem[wrPtr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_baud_inc <= DEFAULT_BAUD_INC;
      wrPtr       <= '0;
      rdPtr       <= '0;
      fifo_count  <= '0;
      fifo_empty  <= 1'b1;
      overflow    <= 1'b0;
      err_count   <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      pkt_done    <= 1'b0;
      pkt_len     <= '0;
      byteCnt     <= '0;
    end else begin
      // Hold the rate while a frame may be in flight
      if (state == OFF || rx_idle) rx_baud_inc <= cfg_baud_inc;

      fifo_count <= countNext;
      fifo_empty <= (countNext == '0);
      rd_valid   <= rdAcc;
      pkt_done   <= 1'b0;

      if (rdAcc) rd_data <= mem[rdPtr];

      if (cfg_flush) begin
        wrPtr     <= '0;
        rdPtr     <= '0;
        overflow  <= 1'b0;
        err_count <= '0;
      end else begin
        if (wrAcc) wrPtr <= wrPtr + FIFO_AW'(1);
        if (rdAcc) rdPtr <= rdPtr + FIFO_AW'(1);
        if (dropByte) overflow <= 1'b1;
        if (isActive && rx_data_error && err_count != 8'hFF)
          err_count <= err_count + 8'd1;
      end

      // Packet byte counter, cleared at packet end or outside ACTIVE
      if (!isActive) begin
        byteCnt <= '0;
      end else if (rx_endofpacket && byteCnt != '0) begin
        pkt_done <= 1'b1;
        pkt_len  <= byteCnt;
        byteCnt  <= '0;
      end else if (rx_data_ready && byteCnt != 8'hFF) begin
        byteCnt <= byteCnt + 8'd1;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_targ_uart_rx_ctrl.sv
// Directed self-checking bench for targ_uart_rx_ctrl.
module tb_targ_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_enable, cfg_flush;
  logic [15:0] cfg_baud_inc;
  logic [15:0] rx_baud_inc;
  logic        rx_data_ready, rx_data_error, rx_endofpacket, rx_idle;
  logic [7:0]  rx_data;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [4:0]  fifo_count;
  logic        fifo_empty, overflow, pkt_done;
  logic [7:0]  err_count, pkt_len;
  logic [1:0]  state_o;

  int passCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  targ_uart_rx_ctrl dut (
    .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_flush(cfg_flush),
    .cfg_baud_inc(cfg_baud_inc), .rx_baud_inc(rx_baud_inc),
    .rx_data_ready(rx_data_ready), .rx_data_error(rx_data_error), .rx_data(rx_data),
    .rx_endofpacket(rx_endofpacket), .rx_idle(rx_idle), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
    .fifo_empty(fifo_empty), .overflow(overflow), .err_count(err_count),
    .pkt_done(pkt_done), .pkt_len(pkt_len), .state_o(state_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_data = b; rx_data_ready = 1'b1;
    tick();
    rx_data_ready = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    totalCnt++; if (state_o !== 2'd0) $display("FAIL reset_state got %0d exp 0", state_o); else passCnt++;
    totalCnt++; if (fifo_count !== 5'd0) $display("FAIL reset_count got %0d exp 0", fifo_count); else passCnt++;
    totalCnt++; if (fifo_empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", fifo_empty); else passCnt++;
    totalCnt++; if (overflow !== 1'b0 || err_count !== 8'd0) $display("FAIL reset_ovf_err got %b/%0d exp 0/0", overflow, err_count); else passCnt++;
    totalCnt++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) $display("FAIL reset_rd got %b/%h exp 0/00", rd_valid, rd_data); else passCnt++;
    totalCnt++; if (pkt_done !== 1'b0 || pkt_len !== 8'd0) $display("FAIL reset_pkt got %b/%0d exp 0/0", pkt_done, pkt_len); else passCnt++;
    totalCnt++; if (rx_baud_inc !== 16'h0000) $display("FAIL reset_baud got %h exp 0000", rx_baud_inc); else passCnt++;
  endtask

  task automatic test_enable();
    cfg_enable = 1'b1; rx_idle = 1'b0;
    rx_data = 8'hEE; rx_data_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      totalCnt++; if (state_o !== 2'd1) $display("FAIL wait_idle_state cyc %0d got %0d exp 1", i, state_o); else passCnt++;
    end
    rx_data_ready = 1'b0;
    rx_idle = 1'b1;
    tick();
    totalCnt++; if (state_o !== 2'd2) $display("FAIL active_state got %0d exp 2", state_o); else passCnt++;
    totalCnt++; if (fifo_count !== 5'd0) $display("FAIL wait_idle_drop got %0d exp 0", fifo_count); else passCnt++;
  endtask

  task automatic test_packet();
    logic [7:0] exp [3];
    exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
    for (int i = 0; i < 3; i++) push(exp[i]);
    totalCnt++; if (fifo_count !== 5'd3) $display("FAIL pkt_count got %0d exp 3", fifo_count); else passCnt++;
    rx_endofpacket = 1'b1;
    tick();
    rx_endofpacket = 1'b0;
    totalCnt++; if (pkt_done !== 1'b1 || pkt_len !== 8'd3) $display("FAIL pkt_done got %b/%0d exp 1/3", pkt_done, pkt_len); else passCnt++;
    tick();
    totalCnt++; if (pkt_done !== 1'b0) $display("FAIL pkt_done_pulse got %b exp 0", pkt_done); else passCnt++;
    for (int i = 0; i < 3; i++) begin
      pop();
      totalCnt++; if (rd_valid !== 1'b1 || rd_data !== exp[i]) $display("FAIL pkt_read %0d got %b/%h exp 1/%h", i, rd_valid, rd_data, exp[i]); else passCnt++;
    end
    totalCnt++; if (fifo_empty !== 1'b1) $display("FAIL pkt_empty got %b exp 1", fifo_empty); else passCnt++;
    tick();
    totalCnt++; if (rd_valid !== 1'b0) $display("FAIL rd_valid_pulse got %b exp 0", rd_valid); else passCnt++;
  endtask

  task automatic test_overflow();
    logic [7:0] expB;
    for (int i = 0; i < 17; i++) push(8'(8'h10 + i));
    totalCnt++; if (fifo_count !== 5'd16 || overflow !== 1'b1) $display("FAIL ovf_full got %0d/%b exp 16/1", fifo_count, overflow); else passCnt++;
    rd_en = 1'b1; rx_data = 8'hAA; rx_data_ready = 1'b1;
    tick();
    rd_en = 1'b0; rx_data_ready = 1'b0;
    totalCnt++; if (rd_valid !== 1'b1 || rd_data !== 8'h10) $display("FAIL full_rw_read got %b/%h exp 1/10", rd_valid, rd_data); else passCnt++;
    totalCnt++; if (fifo_count !== 5'd16 || overflow !== 1'b1) $display("FAIL full_rw_count got %0d/%b exp 16/1", fifo_count, overflow); else passCnt++;
    for (int i = 0; i < 16; i++) begin
      expB = (i == 15) ? 8'hAA : 8'(8'h11 + i);
      pop();
      totalCnt++; if (rd_data !== expB) $display("FAIL drain %0d got %h exp %h", i, rd_data, expB); else passCnt++;
    end
    totalCnt++; if (fifo_empty !== 1'b1) $display("FAIL drain_empty got %b exp 1", fifo_empty); else passCnt++;
  endtask

  task automatic test_errors();
    push(8'h55);
    for (int i = 0; i < 3; i++) begin
      rx_data_error = 1'b1; tick(); rx_data_error = 1'b0; tick();
    end
    totalCnt++; if (err_count !== 8'd3 || fifo_count !== 5'd1) $display("FAIL err3 got %0d/%0d exp 3/1", err_count, fifo_count); else passCnt++;
    rx_data_error = 1'b1;
    for (int i = 0; i < 297; i++) tick();
    rx_data_error = 1'b0;
    totalCnt++; if (err_count !== 8'd255) $display("FAIL err_sat got %0d exp 255", err_count); else passCnt++;
    push(8'h66);
    for (int i = 0; i < 16; i++) push(8'h77);
    totalCnt++; if (overflow !== 1'b1) $display("FAIL pre_flush_ovf got %b exp 1", overflow); else passCnt++;
    cfg_flush = 1'b1; rd_en = 1'b1;
    tick();
    cfg_flush = 1'b0; rd_en = 1'b0;
    totalCnt++; if (err_count !== 8'd0 || overflow !== 1'b0) $display("FAIL flush_clr got %0d/%b exp 0/0", err_count, overflow); else passCnt++;
    totalCnt++; if (fifo_count !== 5'd0 || fifo_empty !== 1'b1) $display("FAIL flush_count got %0d/%b exp 0/1", fifo_count, fifo_empty); else passCnt++;
    totalCnt++; if (rd_valid !== 1'b0) $display("FAIL flush_rd got %b exp 0", rd_valid); else passCnt++;
    totalCnt++; if (state_o !== 2'd2) $display("FAIL flush_state got %0d exp 2", state_o); else passCnt++;
  endtask

  task automatic test_baud();
    cfg_baud_inc = 16'h04EB;
    tick();
    totalCnt++; if (rx_baud_inc !== 16'h04EB) $display("FAIL baud_idle got %h exp 04EB", rx_baud_inc); else passCnt++;
    rx_idle = 1'b0;
    tick();
    cfg_baud_inc = 16'h09D5;
    tick(); tick();
    totalCnt++; if (rx_baud_inc !== 16'h04EB) $display("FAIL baud_hold got %h exp 04EB", rx_baud_inc); else passCnt++;
    rx_idle = 1'b1;
    tick();
    totalCnt++; if (rx_baud_inc !== 16'h09D5) $display("FAIL baud_update got %h exp 09D5", rx_baud_inc); else passCnt++;
  endtask

  task automatic test_disable();
    push(8'h61); push(8'h62);
    cfg_enable = 1'b0;
    tick();
    totalCnt++; if (state_o !== 2'd0) $display("FAIL dis_state got %0d exp 0", state_o); else passCnt++;
    push(8'h99);
    totalCnt++; if (fifo_count !== 5'd2) $display("FAIL dis_ignore got %0d exp 2", fifo_count); else passCnt++;
    pop();
    totalCnt++; if (rd_valid !== 1'b1 || rd_data !== 8'h61) $display("FAIL dis_read0 got %b/%h exp 1/61", rd_valid, rd_data); else passCnt++;
    pop();
    totalCnt++; if (rd_valid !== 1'b1 || rd_data !== 8'h62) $display("FAIL dis_read1 got %b/%h exp 1/62", rd_valid, rd_data); else passCnt++;
  endtask

  task automatic test_reset_mid();
    cfg_enable = 1'b1;
    tick(); tick();
    totalCnt++; if (state_o !== 2'd2) $display("FAIL reen_state got %0d exp 2", state_o); else passCnt++;
    push(8'hC1); push(8'hC2);
    rx_endofpacket = 1'b1; tick(); rx_endofpacket = 1'b0;
    totalCnt++; if (pkt_len !== 8'd2) $display("FAIL reen_pkt got %0d exp 2", pkt_len); else passCnt++;
    pop();
    rx_data_error = 1'b1; tick(); rx_data_error = 1'b0;
    cfg_baud_inc = 16'h1234;
    reset = 1'b1;
    tick();
    totalCnt++; if (state_o !== 2'd0 || fifo_count !== 5'd0 || fifo_empty !== 1'b1) $display("FAIL mid_rst_fifo got %0d/%0d/%b exp 0/0/1", state_o, fifo_count, fifo_empty); else passCnt++;
    totalCnt++; if (err_count !== 8'd0 || pkt_len !== 8'd0 || rd_data !== 8'h00) $display("FAIL mid_rst_regs got %0d/%0d/%h exp 0/0/00", err_count, pkt_len, rd_data); else passCnt++;
    totalCnt++; if (rx_baud_inc !== 16'h0000) $display("FAIL mid_rst_baud got %h exp 0000", rx_baud_inc); else passCnt++;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_enable = 1'b0; cfg_flush = 1'b0; cfg_baud_inc = 16'h0000;
    rx_data_ready = 1'b0; rx_data_error = 1'b0; rx_data = 8'h00;
    rx_endofpacket = 1'b0; rx_idle = 1'b0; rd_en = 1'b0;
    test_reset();
    test_enable();
    test_packet();
    test_overflow();
    test_errors();
    test_baud();
    test_disable();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/targ_uart_rx_ctrl.md
Name: targ_uart_rx_ctrl

Overview:
- Controller/buffer behind the target-side UART receiver (`targ_async_receiver`).
- Drives the receiver's baud increment.
- Gates reception until the line is idle after enable, pushes good bytes into an internal FIFO, and counts framing errors.
- Reports packet boundaries and exposes a registered read port to the host register block.

Parameters:
- FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW entries.
- BAUD_W, 16, width of baud increment (matches receiver accumulator width).
- DEFAULT_BAUD_INC, 16'd0, reset value of rx_baud_inc.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_enable  in  1  level; 1 = reception enabled.
- cfg_flush  in  1  one-cycle pulse; clears FIFO, overflow flag, error count.
- cfg_baud_inc  in  BAUD_W  requested baud increment.
- rx_baud_inc  out  BAUD_W  applied increment, to receiver.
- rx_data_ready  in  1  receiver: byte valid pulse.
- rx_data_error  in  1  receiver: stop-bit error pulse.
- rx_data  in  8  receiver data byte.
- rx_endofpacket  in  1  receiver: gap-detected pulse.
- rx_idle  in  1  receiver: line idle level.
- rd_en  in  1  host read request.
- rd_data  out  8  read byte.
- rd_valid  out  1  one-cycle pulse; rd_data valid.
- fifo_count  out  FIFO_AW+1  current occupancy.
- fifo_empty  out  1  fifo_count==0.
- overflow  out  1  sticky: byte dropped on full FIFO.
- err_count  out  8  saturating framing-error count.
- pkt_done  out  1  one-cycle pulse at end of a non-empty packet.
- pkt_len  out  8  byte count of last completed packet, saturating at 255.
- state_o  out  2  current FSM state (debug).

Behaviour:
- Reset values:
  - rx_baud_inc = DEFAULT_BAUD_INC.
  - FIFO empty, fifo_count = 0, fifo_empty = 1.
  - overflow = 0, err_count = 0.
  - rd_valid = 0, rd_data = 0.
  - pkt_done = 0, pkt_len = 0, internal byte counter = 0.
  - State = OFF.
- FSM states: OFF=0, WAIT_IDLE=1, ACTIVE=2.
  - OFF -> WAIT_IDLE when cfg_enable=1.
  - WAIT_IDLE -> ACTIVE when rx_idle=1 and cfg_enable=1.
  - Any state -> OFF when cfg_enable=0, effective the next cycle.
  - Value 3 is illegal and recovers to OFF.
- Baud update: rx_baud_inc <= cfg_baud_inc on any cycle where state==OFF or rx_idle==1. Otherwise held, so a character is never sampled at a changed rate mid-frame.
- Byte acceptance: only in ACTIVE.
  - rx_data_ready with space: write rx_data, fifo_count+1 next cycle, byte counter +1 (saturating at 255).
  - Space exists if fifo_count < 2^FIFO_AW, or if a read is accepted in the same cycle.
  - rx_data_ready with no space: byte dropped, overflow <= 1, byte counter still increments.
  - rx_data_error in ACTIVE: err_count +1 (saturating at 255); nothing written.
  - rx_data_ready/rx_data_error outside ACTIVE are ignored entirely.
- Reads:
  - rd_en with FIFO non-empty: rd_data = head byte and rd_valid = 1 on the next cycle (latency 1); count -1.
  - rd_en on empty FIFO is ignored (no rd_valid).
  - Simultaneous accepted read and write: count unchanged.
  - Pointers wrap modulo 2^FIFO_AW.
- Packets: rx_endofpacket in ACTIVE with byte counter > 0 produces, next cycle:
  - pkt_done = 1 for one cycle;
  - pkt_len = counter;
  - counter cleared.
  - With counter == 0 it is ignored.
  - Counter also clears on leaving ACTIVE.
- Flush:
  - Takes priority over same-cycle read and write; both are discarded, no rd_valid.
  - Next cycle: count = 0, overflow = 0, err_count = 0, pointers = 0.
  - State and pkt_len are unaffected.
- Disable mid-operation: FIFO contents are retained and remain readable in OFF.
- Reset mid-operation returns everything to reset values in the next cycle.

Test Plan:
- Reset, then cfg_enable=1 with rx_idle=0 for 5 cycles, then rx_idle=1 -> state_o 0->1, stays 1 for 5 cycles, reaches 2 one cycle after rx_idle rises. rx_data_ready pulses during WAIT_IDLE are not stored (fifo_count=0).
- In ACTIVE, push 0x41,0x42,0x43, then rx_endofpacket -> fifo_count=3, pkt_done pulses once with pkt_len=3. Three rd_en reads return rd_data 0x41,0x42,0x43, each with rd_valid one cycle after rd_en. fifo_empty=1 after the last read.
- FIFO_AW=4: push 17 bytes without reads -> fifo_count=16, overflow=1, 17th byte absent. Then same-cycle rd_en and rx_data_ready at full -> both accepted, count stays 16, overflow unchanged.
- Error counting: 3 rx_data_error pulses -> err_count=3, fifo_count unchanged. 300 pulses -> err_count=255. cfg_flush -> err_count=0, overflow=0, fifo_count=0; a same-cycle rd_en gives no rd_valid.
- Baud gating: rx_idle=0 in ACTIVE, change cfg_baud_inc 0x04EB->0x09D5 -> rx_baud_inc holds 0x04EB. rx_idle=1 -> rx_baud_inc=0x09D5 one cycle later.
- Disable with 2 bytes buffered -> state_o=0 next cycle; further rx_data_ready is ignored; both bytes still readable. Assert reset -> all outputs return to reset values the following cycle.
